// File: rtl/zbb_count_unit_if.sv
// Request/response bundle for zbb_count_unit: request side (in_*) and result side (out_*).
// The slave modport is the unit's view; master is the producer/consumer's view.
interface zbb_count_unit_if #(parameter int TAG_W = 5);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_rs1;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport master (
    output in_valid, in_op, in_rs1, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag, out_illegal
  );
endinterface

// File: rtl/zbb_count_unit.sv
// zbb_count_unit: 2-stage CPOP/CLZ/CTZ pipeline with valid/ready handshake and flush.
// Define ZBB_CLZ_CTZ_EN to build CLZ/CTZ; otherwise ops 01/10 return 0 flagged illegal.
module zbb_count_unit #(
  parameter int TAG_W = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  zbb_count_unit_if.slave bus
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [31:0]      w;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } s1_t;

  typedef struct packed {
    logic [5:0]       cnt;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_q, s1_d;
  s2_t             s2_q;
  logic            s2_adv, s1_adv;

  function automatic logic [5:0] popcount32(input logic [31:0] x);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + {5'd0, x[i]};
    return n;
  endfunction

  assign s2_adv       = !vld_pipe[2] || bus.out_ready;
  assign s1_adv       = !vld_pipe[1] || s2_adv;
  assign bus.in_ready = s1_adv;

  // Every op reduces to a popcount: trailing zeros become a mask of ones below the
  // lowest set bit, and leading zeros are trailing zeros of the bit-reversed word.
`ifdef ZBB_CLZ_CTZ_EN
  logic [31:0] rev;
  always_comb begin
    rev = '0;
    for (int i = 0; i < 32; i++) rev[i] = bus.in_rs1[31-i];
  end

  always_comb begin
    s1_d = '{w: 32'd0, tag: bus.in_tag, ill: 1'b0};
    case (bus.in_op)
      2'b00:   s1_d.w = bus.in_rs1;
      2'b01:   s1_d.w = ~rev & (rev - 32'd1);
      2'b10:   s1_d.w = ~bus.in_rs1 & (bus.in_rs1 - 32'd1);
      default: s1_d.ill = 1'b1;
    endcase
  end
`else
  always_comb begin
    s1_d = '{w: 32'd0, tag: bus.in_tag, ill: 1'b0};
    if (bus.in_op == 2'b00) s1_d.w   = bus.in_rs1;
    else                    s1_d.ill = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        s2_q        <= '{cnt: popcount32(s1_q.w), tag: s1_q.tag, ill: s1_q.ill};
      end
      if (s1_adv) begin
        vld_pipe[1] <= bus.in_valid;
        s1_q        <= s1_d;
      end
    end
  end

  assign bus.out_valid   = vld_pipe[2];
  assign bus.out_result  = {26'd0, s2_q.cnt};
  assign bus.out_tag     = s2_q.tag;
  assign bus.out_illegal = s2_q.ill;
endmodule
